// File: rtl/cursor_box_datapath.sv
// Cursor position/colour register with clamp-or-wrap stepping, plus a
// BOX_W x BOX_H rectangle scanner that streams pixel writes over valid/ready.
module cursor_box_datapath #(
  parameter int                     X_W            = 8,
  parameter int                     Y_W            = 7,
  parameter int                     COLOUR_W       = 3,
  parameter int                     X_MAX          = 159,
  parameter int                     Y_MAX          = 119,
  parameter int                     STEP           = 1,
  parameter int                     BOX_W          = 4,
  parameter int                     BOX_H          = 4,
  parameter bit                     WRAP           = 1'b0,
  parameter logic [COLOUR_W-1:0]    DEFAULT_COLOUR = 3'b100,
  parameter logic [COLOUR_W-1:0]    BG_COLOUR      = 3'b000
) (
  input  logic                clock,
  input  logic                reset_from_controller,
  input  logic                mv_x_en,
  input  logic                mv_right,
  input  logic                mv_y_en,
  input  logic                mv_down,
  input  logic                colour_ld,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                draw_start,
  input  logic                erase,
  input  logic                pix_ready,
  input  logic                ovr_en,
  input  logic [X_W-1:0]      ovr_x,
  input  logic [Y_W-1:0]      ovr_y,
  input  logic [COLOUR_W-1:0] ovr_colour,
  output logic [X_W-1:0]      cur_x,
  output logic [Y_W-1:0]      cur_y,
  output logic [COLOUR_W-1:0] cur_colour,
  output logic                pix_valid,
  output logic [X_W-1:0]      pix_x,
  output logic [Y_W-1:0]      pix_y,
  output logic [COLOUR_W-1:0] pix_colour,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Last legal cursor position keeps the whole box on screen.
  localparam logic [X_W:0]   C_XL      = (X_W+1)'(X_MAX - BOX_W + 1);
  localparam logic [Y_W:0]   C_YL      = (Y_W+1)'(Y_MAX - BOX_H + 1);
  localparam logic [X_W:0]   C_STEP_X  = (X_W+1)'(STEP);
  localparam logic [Y_W:0]   C_STEP_Y  = (Y_W+1)'(STEP);
  localparam logic [X_W-1:0] C_OX_LAST = X_W'(BOX_W - 1);
  localparam logic [Y_W-1:0] C_OY_LAST = Y_W'(BOX_H - 1);
  localparam logic [X_W-1:0] C_X_ONE   = X_W'(1);
  localparam logic [Y_W-1:0] C_Y_ONE   = Y_W'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [X_W-1:0]        r_cur_x;
  logic [Y_W-1:0]        r_cur_y;
  logic [COLOUR_W-1:0]   r_cur_colour;
  logic [X_W-1:0]        r_org_x;
  logic [Y_W-1:0]        r_org_y;
  logic [COLOUR_W-1:0]   r_draw_colour;
  logic [X_W-1:0]        r_ox;
  logic [Y_W-1:0]        r_oy;

  logic [X_W:0]          w_x_ext;
  logic [X_W:0]          w_x_inc;
  logic [X_W-1:0]        w_x_dec;
  logic [Y_W:0]          w_y_ext;
  logic [Y_W:0]          w_y_inc;
  logic [Y_W-1:0]        w_y_dec;
  logic [X_W-1:0]        w_nxt_x;
  logic [Y_W-1:0]        w_nxt_y;

  logic                  w_pix_valid;
  logic [X_W-1:0]        w_pix_x;
  logic [Y_W-1:0]        w_pix_y;
  logic [COLOUR_W-1:0]   w_pix_colour;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_xfer;

  // Extra top bit catches overflow past the legal limit before truncation.
  assign w_x_ext = {1'b0, r_cur_x};
  assign w_x_inc = w_x_ext + C_STEP_X;
  assign w_x_dec = r_cur_x - C_STEP_X[X_W-1:0];
  assign w_y_ext = {1'b0, r_cur_y};
  assign w_y_inc = w_y_ext + C_STEP_Y;
  assign w_y_dec = r_cur_y - C_STEP_Y[Y_W-1:0];

  always_comb begin
    w_nxt_x = r_cur_x;
    if (mv_x_en) begin
      if (mv_right) begin
        if (w_x_inc > C_XL) w_nxt_x = WRAP ? '0 : C_XL[X_W-1:0];
        else                w_nxt_x = w_x_inc[X_W-1:0];
      end else begin
        if (w_x_ext < C_STEP_X) w_nxt_x = WRAP ? C_XL[X_W-1:0] : '0;
        else                    w_nxt_x = w_x_dec;
      end
    end
  end

  always_comb begin
    w_nxt_y = r_cur_y;
    if (mv_y_en) begin
      if (mv_down) begin
        if (w_y_inc > C_YL) w_nxt_y = WRAP ? '0 : C_YL[Y_W-1:0];
        else                w_nxt_y = w_y_inc[Y_W-1:0];
      end else begin
        if (w_y_ext < C_STEP_Y) w_nxt_y = WRAP ? C_YL[Y_W-1:0] : '0;
        else                    w_nxt_y = w_y_dec;
      end
    end
  end

  // Handshake: a pixel transfers on any cycle with pix_valid & pix_ready;
  // while pix_valid is high and pix_ready low, all pix_* hold stable.
  always_comb begin
    w_state_nxt  = r_state;
    w_pix_valid  = 1'b0;
    w_pix_x      = r_cur_x;
    w_pix_y      = r_cur_y;
    w_pix_colour = r_cur_colour;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_xfer       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ovr_en) begin
          w_pix_valid  = 1'b1;
          w_pix_x      = ovr_x;
          w_pix_y      = ovr_y;
          w_pix_colour = ovr_colour;
        end
        if (draw_start) w_state_nxt = S_DRAW;
      end
      S_DRAW: begin
        w_pix_valid  = 1'b1;
        w_pix_x      = r_org_x + r_ox;
        w_pix_y      = r_org_y + r_oy;
        w_pix_colour = r_draw_colour;
        w_busy       = 1'b1;
        w_xfer       = pix_ready;
        if (w_xfer && (r_ox == C_OX_LAST) && (r_oy == C_OY_LAST))
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_from_controller) r_state <= S_IDLE;
    else                       r_state <= w_state_nxt;
  end

  // Moves and colour loads only take effect in IDLE and lose to draw_start.
  always_ff @(posedge clock) begin
    if (reset_from_controller) begin
      r_cur_x       <= '0;
      r_cur_y       <= '0;
      r_cur_colour  <= DEFAULT_COLOUR;
      r_org_x       <= '0;
      r_org_y       <= '0;
      r_draw_colour <= '0;
      r_ox          <= '0;
      r_oy          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (draw_start) begin
            r_org_x       <= r_cur_x;
            r_org_y       <= r_cur_y;
            r_draw_colour <= erase ? BG_COLOUR : r_cur_colour;
            r_ox          <= '0;
            r_oy          <= '0;
          end else begin
            r_cur_x <= w_nxt_x;
            r_cur_y <= w_nxt_y;
            if (colour_ld) r_cur_colour <= colour_in;
          end
        end
        S_DRAW: begin
          if (w_xfer) begin
            if (r_ox == C_OX_LAST) begin
              r_ox <= '0;
              if (r_oy == C_OY_LAST) r_oy <= '0;
              else                   r_oy <= r_oy + C_Y_ONE;
            end else begin
              r_ox <= r_ox + C_X_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cur_x      = r_cur_x;
  assign cur_y      = r_cur_y;
  assign cur_colour = r_cur_colour;
  assign pix_valid  = w_pix_valid;
  assign pix_x      = w_pix_x;
  assign pix_y      = w_pix_y;
  assign pix_colour = w_pix_colour;
  assign busy       = w_busy;
  assign done       = w_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_cursor_box_datapath.sv
// Bench for cursor_box_datapath: a clamp and a wrap instance share stimulus and
// are checked against a queue-based reference model plus directed sequences.
module tb_cursor_box_datapath;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int CW  = 3;
  localparam int XL  = 156;
  localparam int YL  = 116;
  localparam int STEP = 1;
  localparam int BW  = 4;
  localparam int BH  = 4;
  localparam logic [CW-1:0] DEF_COL = 3'b100;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_from_controller;
  logic          mv_x_en, mv_right, mv_y_en, mv_down;
  logic          colour_ld;
  logic [CW-1:0] colour_in;
  logic          draw_start, erase, pix_ready, ovr_en;
  logic [X_W-1:0] ovr_x;
  logic [Y_W-1:0] ovr_y;
  logic [CW-1:0]  ovr_colour;

  logic [X_W-1:0] cl_cur_x, wr_cur_x, cl_pix_x, wr_pix_x;
  logic [Y_W-1:0] cl_cur_y, wr_cur_y, cl_pix_y, wr_pix_y;
  logic [CW-1:0]  cl_cur_colour, wr_cur_colour, cl_pix_colour, wr_pix_colour;
  logic           cl_pix_valid, wr_pix_valid, cl_busy, wr_busy, cl_done, wr_done;
  logic [1:0]     cl_dbg, wr_dbg;

  cursor_box_datapath #(.WRAP(1'b0)) u_clamp (
    .clock(clock), .reset_from_controller(reset_from_controller),
    .mv_x_en(mv_x_en), .mv_right(mv_right), .mv_y_en(mv_y_en), .mv_down(mv_down),
    .colour_ld(colour_ld), .colour_in(colour_in), .draw_start(draw_start), .erase(erase),
    .pix_ready(pix_ready), .ovr_en(ovr_en), .ovr_x(ovr_x), .ovr_y(ovr_y),
    .ovr_colour(ovr_colour), .cur_x(cl_cur_x), .cur_y(cl_cur_y), .cur_colour(cl_cur_colour),
    .pix_valid(cl_pix_valid), .pix_x(cl_pix_x), .pix_y(cl_pix_y), .pix_colour(cl_pix_colour),
    .busy(cl_busy), .done(cl_done), .dbg_state(cl_dbg)
  );

  cursor_box_datapath #(.WRAP(1'b1)) u_wrap (
    .clock(clock), .reset_from_controller(reset_from_controller),
    .mv_x_en(mv_x_en), .mv_right(mv_right), .mv_y_en(mv_y_en), .mv_down(mv_down),
    .colour_ld(colour_ld), .colour_in(colour_in), .draw_start(draw_start), .erase(erase),
    .pix_ready(pix_ready), .ovr_en(ovr_en), .ovr_x(ovr_x), .ovr_y(ovr_y),
    .ovr_colour(ovr_colour), .cur_x(wr_cur_x), .cur_y(wr_cur_y), .cur_colour(wr_cur_colour),
    .pix_valid(wr_pix_valid), .pix_x(wr_pix_x), .pix_y(wr_pix_y), .pix_colour(wr_pix_colour),
    .busy(wr_busy), .done(wr_done), .dbg_state(wr_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cursor as integers, scan as a queue of pending pixels.
  localparam int PW = X_W + Y_W + CW;
  logic [PW-1:0] exp_q[$];
  int            m_x[2];
  int            m_y[2];
  logic [CW-1:0] m_col;
  bit            m_done;

  function automatic int step_coord(input int v, input int lim, input bit plus, input bit wrap);
    int n;
    n = plus ? v + STEP : v - STEP;
    if (n > lim) return wrap ? 0 : lim;
    if (n < 0)   return wrap ? lim : 0;
    return n;
  endfunction

  always @(posedge clock) begin
    if (reset_from_controller) begin
      for (int i = 0; i < 2; i++) begin
        m_x[i] = 0;
        m_y[i] = 0;
      end
      m_col  = DEF_COL;
      m_done = 1'b0;
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      if (pix_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (draw_start) begin
      for (int oy = 0; oy < BH; oy++)
        for (int ox = 0; ox < BW; ox++)
          exp_q.push_back({X_W'(m_x[0] + ox), Y_W'(m_y[0] + oy), (erase ? 3'b000 : m_col)});
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mv_x_en) m_x[i] = step_coord(m_x[i], XL, mv_right, i == 1);
        if (mv_y_en) m_y[i] = step_coord(m_y[i], YL, mv_down, i == 1);
      end
      if (colour_ld) m_col = colour_in;
    end
  end

  always @(negedge clock) begin
    bit scan, exp_busy;
    if (chk_en) begin
      scan     = exp_q.size() > 0;
      exp_busy = scan || m_done;
      chk("cl_cur_x", cl_cur_x, m_x[0]);
      chk("cl_cur_y", cl_cur_y, m_y[0]);
      chk("cl_cur_colour", cl_cur_colour, m_col);
      chk("wr_cur_x", wr_cur_x, m_x[1]);
      chk("wr_cur_y", wr_cur_y, m_y[1]);
      chk("wr_cur_colour", wr_cur_colour, m_col);
      chk("cl_busy", cl_busy, exp_busy);
      chk("wr_busy", wr_busy, exp_busy);
      chk("cl_done", cl_done, m_done);
      chk("wr_done", wr_done, m_done);
      chk("cl_dbg_busy", cl_dbg != 2'd0, exp_busy);
      if (scan) begin
        chk("cl_pix_valid", cl_pix_valid, 1);
        chk("wr_pix_valid", wr_pix_valid, 1);
        chk("cl_pix_x", cl_pix_x, exp_q[0][PW-1 -: X_W]);
        chk("cl_pix_y", cl_pix_y, exp_q[0][CW +: Y_W]);
        chk("cl_pix_colour", cl_pix_colour, exp_q[0][CW-1:0]);
      end else if (m_done) begin
        chk("cl_done_valid", cl_pix_valid, 0);
        chk("wr_done_valid", wr_pix_valid, 0);
      end else begin
        chk("cl_idle_valid", cl_pix_valid, ovr_en);
        chk("wr_idle_valid", wr_pix_valid, ovr_en);
        chk("cl_idle_x", cl_pix_x, ovr_en ? int'(ovr_x) : m_x[0]);
        chk("cl_idle_y", cl_pix_y, ovr_en ? int'(ovr_y) : m_y[0]);
        chk("cl_idle_col", cl_pix_colour, ovr_en ? ovr_colour : m_col);
        chk("wr_idle_x", wr_pix_x, ovr_en ? int'(ovr_x) : m_x[1]);
        chk("wr_idle_y", wr_pix_y, ovr_en ? int'(ovr_y) : m_y[1]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ctrl();
    mv_x_en = 1'b0; mv_right = 1'b0; mv_y_en = 1'b0; mv_down = 1'b0;
    colour_ld = 1'b0; draw_start = 1'b0; erase = 1'b0; ovr_en = 1'b0;
  endtask

  typedef struct {
    bit          xen, right, yen, down, cld;
    logic [2:0]  col;
    int          n;
    int          cx, cy, wx, wy;
    logic [2:0]  ecol;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit   got_done, prev_stall, stall_now;
    int   n_xfer;
    logic [X_W-1:0] prev_x;
    logic [Y_W-1:0] prev_y;
    logic [CW-1:0]  prev_c;
    bit   seen[int];

    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 200, 156, 0,   43,  0,   3'd4};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1,   155, 0,   42,  0,   3'd4};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 43,  112, 0,   156, 0,   3'd4};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 116, 112, 116, 156, 116, 3'd4};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1,   112, 116, 156, 0,   3'd4};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1,   112, 115, 156, 116, 3'd4};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1,   113, 116, 0,   0,   3'd4};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1,   113, 116, 0,   0,   3'd3};

    reset_from_controller = 1'b1;
    clear_ctrl();
    colour_in = '0; pix_ready = 1'b0;
    ovr_x = '0; ovr_y = '0; ovr_colour = '0;
    tick();
    chk_en = 1'b1;

    @(negedge clock);
    chk("rst_cur_x", cl_cur_x, 0);
    chk("rst_cur_y", cl_cur_y, 0);
    chk("rst_colour", cl_cur_colour, 3'b100);
    chk("rst_valid", cl_pix_valid, 0);
    chk("rst_busy", cl_busy, 0);
    reset_from_controller = 1'b0;
    tick();

    // Move table: both instances see the same moves.
    for (int t = 0; t < 8; t++) begin
      mv_x_en = tbl[t].xen; mv_right = tbl[t].right;
      mv_y_en = tbl[t].yen; mv_down = tbl[t].down;
      colour_ld = tbl[t].cld; colour_in = tbl[t].col;
      repeat (tbl[t].n) tick();
      clear_ctrl();
      @(negedge clock);
      chk($sformatf("tbl%0d_cl_x", t), cl_cur_x, tbl[t].cx);
      chk($sformatf("tbl%0d_cl_y", t), cl_cur_y, tbl[t].cy);
      chk($sformatf("tbl%0d_wr_x", t), wr_cur_x, tbl[t].wx);
      chk($sformatf("tbl%0d_wr_y", t), wr_cur_y, tbl[t].wy);
      chk($sformatf("tbl%0d_col", t), cl_cur_colour, tbl[t].ecol);
      tick();
    end

    // Scan at (10,20) with ready held high; moves during the scan are dropped.
    reset_from_controller = 1'b1;
    tick();
    reset_from_controller = 1'b0;
    mv_x_en = 1'b1; mv_right = 1'b1; mv_y_en = 1'b1; mv_down = 1'b1;
    repeat (10) tick();
    mv_x_en = 1'b0;
    repeat (10) tick();
    clear_ctrl();
    pix_ready = 1'b1;
    draw_start = 1'b1;
    tick();
    draw_start = 1'b0;
    mv_x_en = 1'b1; mv_right = 1'b1; mv_y_en = 1'b1; mv_down = 1'b0;
    colour_ld = 1'b1; colour_in = 3'd7;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      chk($sformatf("scan%0d_valid", k), cl_pix_valid, 1);
      chk($sformatf("scan%0d_x", k), cl_pix_x, 10 + k % 4);
      chk($sformatf("scan%0d_y", k), cl_pix_y, 20 + k / 4);
      chk($sformatf("scan%0d_col", k), cl_pix_colour, 3'b100);
      tick();
    end
    clear_ctrl();
    @(negedge clock);
    chk("scan_done_pulse", cl_done, 1);
    chk("scan_done_busy", cl_busy, 1);
    chk("scan_done_valid", cl_pix_valid, 0);
    tick();
    @(negedge clock);
    chk("scan_after_done", cl_done, 0);
    chk("scan_after_busy", cl_busy, 0);
    chk("scan_cur_x_held", cl_cur_x, 10);
    chk("scan_cur_y_held", cl_cur_y, 20);
    chk("scan_colour_held", cl_cur_colour, 3'b100);
    tick();

    // Erase scan under random backpressure.
    erase = 1'b1; draw_start = 1'b1;
    tick();
    clear_ctrl();
    got_done = 1'b0; prev_stall = 1'b0; n_xfer = 0;
    prev_x = '0; prev_y = '0; prev_c = '0;
    seen.delete();
    for (int c = 0; c < 300 && !got_done; c++) begin
      pix_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (prev_stall) begin
        chk("stall_hold_x", cl_pix_x, prev_x);
        chk("stall_hold_y", cl_pix_y, prev_y);
        chk("stall_hold_col", cl_pix_colour, prev_c);
      end
      stall_now = 1'b0;
      if (cl_done) begin
        got_done = 1'b1;
      end else if (cl_pix_valid) begin
        stall_now = !pix_ready;
        prev_x = cl_pix_x; prev_y = cl_pix_y; prev_c = cl_pix_colour;
        if (pix_ready) begin
          n_xfer++;
          chk("erase_colour", cl_pix_colour, 0);
          seen[int'(cl_pix_x) * 256 + int'(cl_pix_y)] = 1'b1;
        end
      end
      prev_stall = stall_now;
      tick();
    end
    chk("bp_done_seen", got_done, 1);
    chk("bp_xfer_count", n_xfer, 16);
    chk("bp_unique", seen.num(), 16);

    // Reset after the fifth pixel aborts the scan.
    pix_ready = 1'b1;
    draw_start = 1'b1;
    tick();
    draw_start = 1'b0;
    repeat (5) tick();
    reset_from_controller = 1'b1;
    tick();
    reset_from_controller = 1'b0;
    @(negedge clock);
    chk("abort_valid", cl_pix_valid, 0);
    chk("abort_busy", cl_busy, 0);
    chk("abort_cur_x", cl_cur_x, 0);
    chk("abort_cur_y", cl_cur_y, 0);
    got_done = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      @(negedge clock);
      if (cl_done) got_done = 1'b1;
    end
    chk("abort_no_done", got_done, 0);
    tick();

    // Override write in IDLE is combinational.
    ovr_en = 1'b1; ovr_x = 8'd100; ovr_y = 7'd50; ovr_colour = 3'b010;
    @(negedge clock);
    chk("ovr_valid", cl_pix_valid, 1);
    chk("ovr_x", cl_pix_x, 100);
    chk("ovr_y", cl_pix_y, 50);
    chk("ovr_col", cl_pix_colour, 3'b010);
    tick();
    clear_ctrl();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      reset_from_controller = ($urandom_range(0, 199) == 0);
      mv_x_en    = 1'($urandom_range(0, 1));
      mv_right   = 1'($urandom_range(0, 1));
      mv_y_en    = 1'($urandom_range(0, 1));
      mv_down    = 1'($urandom_range(0, 1));
      colour_ld  = ($urandom_range(0, 7) == 0);
      colour_in  = 3'($urandom_range(0, 7));
      draw_start = ($urandom_range(0, 15) == 0);
      erase      = 1'($urandom_range(0, 1));
      pix_ready  = ($urandom_range(0, 3) != 0);
      ovr_en     = ($urandom_range(0, 3) == 0);
      ovr_x      = 8'($urandom_range(0, 159));
      ovr_y      = 7'($urandom_range(0, 119));
      ovr_colour = 3'($urandom_range(0, 7));
      tick();
    end
    reset_from_controller = 1'b0;
    clear_ctrl();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
